mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the data-memory bus, alongside the data RAM, downstream of the CPU's store path. It accepts bytes written by the CPU to its address window and queues them in a small FIFO. It serializes them as 8N1 frames on a `tx` pin and exposes a readable status word. Its read output is zero outside its window, so the SoC ORs it with the RAM read data.

## Interface
Parameters:
- BASE_ADDR, 32'hFFFF_0000, 8-byte-aligned base of the register window.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥ 2.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- addr_bus, input, 32, CPU data address.
- write_data_bus, input, 32, CPU store data.
- write_signal, input, 1, store strobe; each rising edge with it high is one write.
- read_data_bus, output, 32, register read data; combinational; 0 when the window is not hit.
- hit, output, 1, combinational; high when addr_bus is inside the window.
- tx, output, 1, serial line; idles high.

## Operation
- Decode: hit = (addr_bus[31:3] == BASE_ADDR[31:3]). addr_bus[2] selects the register; addr_bus[1:0] are ignored.
- Offset 0, TXDATA:
  - Write pushes write_data_bus[7:0]; upper bits are ignored.
  - Read returns 0.
- Offset 4, STATUS:
  - Read returns {28'b0, overflow, busy, empty, full}.
  - Write with write_data_bus[3]=1 clears overflow; other bits are ignored.
- FIFO:
  - Registered count 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).
  - A push while full, judged on the registered count, is dropped and sets sticky overflow. This holds even if a pop happens the same cycle.
  - A simultaneous accepted push and pop leaves count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Transmit FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If !empty, pop the head into the shift register, go to START, tx=0.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA with tx = bit0.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7; after bit 7 go to STOP with tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, if !empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Width clog2(CLKS_PER_BIT).
  - Loads CLKS_PER_BIT-1 on every state/bit entry and decrements to 0; a bit ends when it is 0.
- busy = (state != IDLE) || !empty.
- tx is driven from a flop; it never glitches.

## Timing
- Reset (reset==0 at an edge) forces the following on the next edge:
  - state=IDLE, tx=1, count=0, pointers=0, overflow=0, baud counter=0.
  - Combinationally after that edge: read_data_bus = {28'b0,0,0,1,0} when STATUS is read.
- Reset mid-frame aborts the frame: tx returns high on that edge and the queued bytes are discarded.
- Writes and the overflow clear take effect at the edge where write_signal=1. A STATUS read in the following cycle reflects them.
- Latency, idle and empty:
  - A write accepted at edge k gives count=1 after edge k.
  - tx falls at edge k+1 (start bit).
- Frame duration is exactly 10*CLKS_PER_BIT cycles, from the tx falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge immediately after the final stop-bit cycle.
- read_data_bus and hit are purely combinational from addr_bus and registered state. The CPU's same-cycle load timing is unchanged.
- Reads have no side effects.

## Test plan
- Reset then idle:
  - Hold reset low 3 cycles, release.
  - Required: tx=1; STATUS read = 32'h2; read at BASE_ADDR+8 = 0 with hit=0.
- Single byte:
  - Write 32'hABCD_0055 to BASE_ADDR.
  - Required: start bit one edge later, then bits 1,0,1,0,1,0,1,0, then stop. Each bit lasts 16 cycles; 160 cycles total.
  - Required: STATUS busy=1 during the frame and 0 afterwards.
- Back-to-back:
  - Write 8'h01, 8'h80, 8'hFF in consecutive cycles.
  - Required: three contiguous frames with no idle cycles between them; 480 cycles total; empty=1 after the first pop of the last byte.
- Overflow:
  - With the FSM busy, write 10 bytes while 8 slots are free.
  - Required: the last 2 bytes are dropped and STATUS shows full=1, overflow=1.
  - Then write 32'h8 to BASE_ADDR+4. Required: overflow=0; exactly 9 frames are transmitted in total (1 in flight + 8 queued).
- Reset mid-frame:
  - Assert reset during DATA bit 3 with 4 bytes queued.
  - Required: tx=1 on the next edge; STATUS = 32'h2; no further frames after release.
- Push/pop collision:
  - With the FIFO full, write on the exact cycle the FSM pops.
  - Required: the write is dropped, overflow=1, and count drops to FIFO_DEPTH-1.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a byte FIFO, a serializer
// FSM drives a registered tx pin, and a status word is readable in the window.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_bus,
    input  logic [31:0] write_data_bus,
    input  logic        write_signal,
    output logic [31:0] read_data_bus,
    output logic        hit,
    output logic        tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       fifo_q [FIFO_DEPTH];

    logic full, empty, busy, push_req, push, pop, ovf_clr;
    logic unused_bits;

    assign hit           = (addr_bus[31:3] == BASE_ADDR[31:3]);
    assign full          = (count_q == CNT_FULL);
    assign empty         = (count_q == '0);
    assign busy          = (state_q != S_IDLE) || !empty;
    assign push_req      = write_signal && hit && !addr_bus[2];
    assign push          = push_req && !full;
    assign ovf_clr       = write_signal && hit && addr_bus[2] && write_data_bus[3];
    assign read_data_bus = (hit && addr_bus[2]) ? {28'b0, ovf_q, busy, empty, full} : 32'b0;
    assign tx            = tx_q;
    assign unused_bits   = ^{write_data_bus[31:8], addr_bus[1:0]};

    // Serializer: every state or bit entry reloads the baud counter; a bit ends at zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = BAUD_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = 3'd0;
                    baud_d  = BAUD_LOAD;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            default: begin
                if (baud_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        baud_d  = BAUD_LOAD;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
        endcase
    end

    // A push is judged on the registered count, so a full FIFO drops it even when a pop coincides.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
        if (push_req && full)  ovf_d = 1'b1;
        else if (ovf_clr)      ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= write_data_bus[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a queue-and-frame-position model checked every
// cycle, a bench-side UART receiver, and directed scenarios with literal expectations.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          CPB   = 16;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr_bus = 32'h0;
    logic [31:0] write_data_bus = 32'h0;
    logic        write_signal = 1'b0;
    logic [31:0] read_data_bus;
    logic        hit;
    logic        tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .write_data_bus(write_data_bus),
        .write_signal(write_signal), .read_data_bus(read_data_bus), .hit(hit), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: pending bytes in a queue, plus the byte on the wire and its cycle position in the frame.
    logic [7:0] mq[$];
    bit         m_in = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h0;
    bit         m_ovf = 1'b0;
    bit         model_ok = 1'b0;

    function automatic logic model_tx();
        int b;
        if (!m_in) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    function automatic logic [31:0] model_status();
        logic e, f;
        e = (mq.size() == 0);
        f = (mq.size() == DEPTH);
        return {28'b0, m_ovf, m_in || !e, e, f};
    endfunction

    always @(posedge clk) begin : model
        bit was_full;
        bit in_win;
        if (!reset) begin
            mq.delete();
            m_in = 1'b0;
            m_pos = 0;
            m_ovf = 1'b0;
            model_ok = 1'b1;
        end else begin
            was_full = (mq.size() == DEPTH);
            in_win = (addr_bus[31:3] == BASE[31:3]);
            if (m_in && m_pos < FRAME - 1) begin
                m_pos++;
            end else if (mq.size() > 0) begin
                m_byte = mq.pop_front();
                m_in = 1'b1;
                m_pos = 0;
            end else begin
                m_in = 1'b0;
            end
            if (write_signal && in_win) begin
                if (!addr_bus[2]) begin
                    if (was_full) m_ovf = 1'b1;
                    else mq.push_back(write_data_bus[7:0]);
                end else if (write_data_bus[3]) begin
                    m_ovf = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic        exp_hit;
        logic [31:0] exp_rd;
        if (model_ok) begin
            exp_hit = (addr_bus[31:3] == BASE[31:3]);
            exp_rd  = (exp_hit && addr_bus[2]) ? model_status() : 32'h0;
            check("tx_vs_model", tx, model_tx());
            check("hit_vs_model", hit, exp_hit);
            check("rdata_vs_model", read_data_bus, exp_rd);
        end
    end

    // Bench UART receiver: samples mid-bit and logs bytes and start cycles.
    logic [7:0] rx_bytes[$];
    int         rx_start[$];
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h0;

    always @(negedge clk) begin
        if (!reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt = 0;
                rx_start.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
                rx_sh[rx_cnt/CPB-1] = tx;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                check("rx_stop_bit", tx, 1);
                rx_bytes.push_back(rx_sh);
                rx_active = 1'b0;
            end
        end
    end

    logic [7:0] exp_q[$];

    task automatic check_rx(input string name);
        check({name, "_count"}, rx_bytes.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), (i < rx_bytes.size()) ? rx_bytes[i] : 8'hxx, exp_q[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        int guard = 0;
        while (cyc < e && guard < 5000) begin
            tick();
            guard++;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int e);
        addr_bus = a;
        write_data_bus = d;
        write_signal = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        write_signal = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((m_in || mq.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check(name, n < 3000, 1);
        tick();
    endtask

    task automatic settle();
        int e;
        wait_idle("settle_idle");
        bus_write(BASE + 4, 32'h8, e);
        tick();
        rx_bytes.delete();
        rx_start.delete();
        exp_q.delete();
    endtask

    initial begin
        int         ka, e, r;
        logic [9:0] pat;

        // Reset, then idle.
        addr_bus = BASE + 4;
        repeat (3) tick();
        reset = 1'b1;
        check("reset_tx", tx, 1);
        check("reset_status", read_data_bus, 32'h2);
        addr_bus = BASE + 8;
        #1;
        check("outside_rdata", read_data_bus, 32'h0);
        check("outside_hit", hit, 0);
        tick();

        // Single byte 0x55: start, 1,0,1,0,1,0,1,0, stop.
        settle();
        pat = 10'b10_1010_1010;
        bus_write(BASE, 32'hABCD_0055, ka);
        check("single_idle_at_accept", tx, 1);
        addr_bus = BASE + 4;
        for (int b = 0; b < 10; b++) begin
            wait_until(ka + 1 + b * CPB + CPB / 2);
            check($sformatf("single_bit%0d", b), tx, pat[b]);
            if (b == 5) check("single_busy_mid", read_data_bus, 32'h6);
        end
        wait_until(ka + FRAME);
        check("single_last_stop_cycle", read_data_bus, 32'h6);
        wait_until(ka + FRAME + 1);
        check("single_after_frame", read_data_bus, 32'h2);
        exp_q = '{8'h55};
        check_rx("single");

        // Back-to-back frames with no idle gap.
        settle();
        bus_write(BASE, 32'h01, ka);
        bus_write(BASE, 32'h80, e);
        bus_write(BASE, 32'hFF, e);
        addr_bus = BASE + 4;
        wait_until(ka + 2 * FRAME);
        check("b2b_empty_before_pop3", read_data_bus[1], 0);
        wait_until(ka + 2 * FRAME + 1);
        check("b2b_empty_after_pop3", read_data_bus[1], 1);
        check("b2b_third_start", tx, 0);
        wait_until(ka + 3 * FRAME);
        check("b2b_busy_at_end", read_data_bus[2], 1);
        wait_until(ka + 3 * FRAME + 1);
        check("b2b_status_done", read_data_bus, 32'h2);
        check("b2b_starts", rx_start.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_start%0d", i), (i < rx_start.size()) ? rx_start[i] : -1,
                  ka + 1 + i * FRAME);
        exp_q = '{8'h01, 8'h80, 8'hFF};
        check_rx("b2b");

        // Overflow: one byte in flight, ten pushes into eight free slots.
        settle();
        bus_write(BASE, 32'hA5, ka);
        tick();
        tick();
        for (int i = 0; i < 10; i++) bus_write(BASE, 32'h10 + i, e);
        addr_bus = BASE + 4;
        #1;
        check("ovf_status", read_data_bus, 32'hD);
        bus_write(BASE + 4, 32'h8, e);
        check("ovf_cleared", read_data_bus, 32'h5);
        wait_idle("ovf_drain");
        exp_q = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        check_rx("ovf");

        // Reset during data bit 3 with four bytes queued.
        settle();
        bus_write(BASE, 32'h31, ka);
        for (int i = 2; i <= 5; i++) bus_write(BASE, 32'h30 + i, e);
        addr_bus = BASE + 4;
        wait_until(ka + 1 + 4 * CPB + 4);
        reset = 1'b0;
        tick();
        check("midreset_tx", tx, 1);
        check("midreset_status", read_data_bus, 32'h2);
        reset = 1'b1;
        repeat (400) tick();
        check("midreset_no_frames", rx_bytes.size(), 0);
        check("midreset_status_after", read_data_bus, 32'h2);

        // Push on the exact cycle the FSM pops from a full FIFO.
        settle();
        bus_write(BASE, 32'hC0, ka);
        for (int i = 1; i <= 8; i++) bus_write(BASE, 32'hC0 + i, e);
        addr_bus = BASE + 4;
        #1;
        check("collide_full", read_data_bus, 32'h5);
        wait_until(ka + FRAME);
        bus_write(BASE, 32'hEE, e);
        check("collide_edge", e, ka + FRAME + 1);
        addr_bus = BASE + 4;
        #1;
        check("collide_status", read_data_bus, 32'hC);
        wait_idle("collide_drain");
        exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
        check_rx("collide");

        // Randomized traffic against the model.
        settle();
        for (int n = 0; n < 6000; n++) begin
            r = $urandom_range(0, 999);
            write_data_bus = $urandom;
            if (r < 15) begin
                addr_bus = BASE | $urandom_range(0, 3);
                write_signal = 1'b1;
            end else if (r < 25) begin
                addr_bus = (BASE + 4) | $urandom_range(0, 3);
                write_signal = 1'b1;
            end else if (r < 30) begin
                addr_bus = $urandom;
                write_signal = 1'b1;
            end else if (r == 999) begin
                reset = 1'b0;
            end else begin
                case ($urandom_range(0, 3))
                    0: addr_bus = BASE;
                    1: addr_bus = BASE + 4;
                    2: addr_bus = BASE + 8;
                    default: addr_bus = $urandom;
                endcase
            end
            tick();
            write_signal = 1'b0;
            reset = 1'b1;
        end
        wait_idle("random_drain");
        check("final_tx_idle", tx, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
